fma_result_collector: RTL and testbench
=======================================

Name: fma_result_collector

Overview:
- Consumer end of the FMA pipeline's valid-out interface. It captures every result (io_out, io_exceptionFlags) that the fixed-latency MulAddRecFNPipe emits, and buffers it in a small FIFO.
- Results drain to writeback through a ready/valid handshake.
- Issue credits are returned to the issuer, so a result the pipe cannot stall is never lost.
- Control and timing depend only on valid/ready/credit signals, never on operand or result values. This keeps the block data-independent-timing clean for the miter flow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_INFLIGHT, 4, maximum operations inside the FMA pipe; sizes the in-flight counter.
- DATA_W, 65, recoded FP result width.
- FLAG_W, 5, exception flag width.

Ports:
- clock, in, 1, single clock; rising edge.
- reset, in, 1, asynchronous active-low reset.
- issue_fire, in, 1, issuer launched an op into the pipe this cycle (mirrors io_validin).
- issue_ready, out, 1, issuer may launch this cycle.
- pipe_valid, in, 1, pipe result valid (io_validout).
- pipe_out, in, DATA_W, pipe result (io_out).
- pipe_flags, in, FLAG_W, pipe exception flags (io_exceptionFlags).
- deq_valid, out, 1, head entry available.
- deq_ready, in, 1, writeback accepts the head.
- deq_data, out, DATA_W, head result.
- deq_flags, out, FLAG_W, head flags.
- fflags_acc, out, FLAG_W, sticky OR of the flags of all dequeued entries.
- fflags_clr, in, 1, clear fflags_acc.
- err_overflow, out, 1, sticky: a result arrived with no space.
- err_credit, out, 1, sticky: issue_fire without issue_ready, or pipe_valid with in-flight count 0.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - FIFO pointers, occupancy count and in-flight counter;
  - fflags_acc, err_overflow and err_credit.
- Output values during reset:
  - deq_valid=0; deq_data=0 and deq_flags=0 (head storage does not need clearing, but outputs are gated to 0 when empty);
  - issue_ready=1.
- Reset mid-operation discards all buffered and in-flight state. The issuer and pipe are reset in the same cycle.
- Enqueue:
  - Occurs on pipe_valid, written at the tail on the next rising edge.
  - No ready path exists toward the pipe.
- Dequeue fire:
  - Defined as deq_fire = deq_valid & deq_ready.
  - deq_valid = (count != 0).
  - deq_data and deq_flags come combinationally from the head entry (FIFO read latency 0).
- Latency: a result enqueued in cycle N is visible on deq_valid in cycle N+1 when the FIFO is empty. There is no bypass.
- Full boundary, count == DEPTH:
  - pipe_valid with deq_fire in the same cycle is accepted; count is unchanged and pointers advance together.
  - pipe_valid without deq_fire drops the entry and sets err_overflow. Count stays at DEPTH.
- Empty boundary: deq_ready is ignored while deq_valid=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- In-flight counter:
  - Increments on issue_fire and decrements on pipe_valid. Simultaneous events leave it unchanged.
  - It saturates at 0 on decrement; the underflow case sets err_credit.
  - It saturates at MAX_INFLIGHT on increment; overflow also sets err_credit.
- Credit rule:
  - issue_ready = (count + inflight) < DEPTH, and inflight < MAX_INFLIGHT.
  - Uses only current registered state; the same-cycle deq_fire is not credited, which is conservative.
- issue_fire while issue_ready=0 sets err_credit. The op is still counted in flight.
- fflags_acc:
  - Next value is (fflags_clr ? 0 : fflags_acc) | (deq_fire ? deq_flags : 0).
  - Clear and dequeue in the same cycle therefore leave only the new flags.
- Error flags are sticky until reset.

Decomposition:
- Shared package fma_collector_pkg:
  - FLAG_W and DATA_W constants;
  - typedef fma_result_t {data, flags};
  - flag bit index constants NV=4, DZ=3, OF=2, UF=1, NX=0.
- One sub-module, fma_result_fifo: a DEPTH-entry storage array with pointers, count, full and empty.
- Credit, in-flight and flag accumulation logic stays in the top.

Test Plan:
- Reset then idle:
  - During reset: issue_ready=1, deq_valid=0, fflags_acc=0, both error flags 0.
- Single op:
  - Stimulus: issue_fire in cycle 0; pipe_valid in cycle 4 with pipe_out=65'h1_0000_0000_3FF0_0000 and flags=5'b00001.
  - Expected: deq_valid in cycle 5 with matching data.
  - With deq_ready=1, the result is consumed and fflags_acc becomes 5'b00001.
- Credit exhaustion:
  - Stimulus: four back-to-back issue_fire with deq_ready=0.
  - Expected: issue_ready=0 after the 4th issue and stays 0 after all four results land (count=4).
  - One dequeue restores issue_ready=1 in the next cycle.
- Full with simultaneous enq/deq:
  - Stimulus: FIFO full; force pipe_valid and deq_ready together.
  - Expected: count stays 4, err_overflow=0, order preserved.
  - Repeat with deq_ready=0: err_overflow=1 and the entry is dropped.
- Flag accumulation:
  - Stimulus: dequeue flags 5'b10000 then 5'b00100, giving fflags_acc=5'b10100; then assert fflags_clr in the same cycle as a dequeue with flags 5'b00001.
  - Expected: fflags_acc=5'b00001.
- Protocol errors and async reset:
  - pipe_valid with inflight=0 sets err_credit=1.
  - Asserting reset low between clock edges with 3 entries buffered immediately forces deq_valid=0, issue_ready=1 and clears both error flags.

Source files
------------

// File: rtl/fma_collector_pkg.sv
// Shared types and constants for the FMA result collector.
package fma_collector_pkg;

    // Recoded FP result width and exception flag width.
    localparam int unsigned DATA_W = 65;
    localparam int unsigned FLAG_W = 5;

    // Exception flag bit positions.
    localparam int unsigned NV = 4;
    localparam int unsigned DZ = 3;
    localparam int unsigned OF = 2;
    localparam int unsigned UF = 1;
    localparam int unsigned NX = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] flags;
    } fma_result_t;

endpackage

// File: rtl/fma_result_fifo.sv
// DEPTH-entry FIFO with zero-latency head read, occupancy count, full and empty.
// The caller must not write when full unless it also reads, and must not read when empty.
module fma_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 70
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is only observed while non-empty.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/fma_result_collector.sv
// Collects results from the fixed-latency FMA pipe into a FIFO, drains them via
// ready/valid, and returns issue credits so an unstallable result always has a slot.
// All control depends only on valid/ready/credit state, never on data values.
module fma_result_collector #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned DATA_W       = fma_collector_pkg::DATA_W,
    parameter int unsigned FLAG_W       = fma_collector_pkg::FLAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_fire,
    output logic              issue_ready,
    input  logic              pipe_valid,
    input  logic [DATA_W-1:0] pipe_out,
    input  logic [FLAG_W-1:0] pipe_flags,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [FLAG_W-1:0] deq_flags,
    output logic [FLAG_W-1:0] fflags_acc,
    input  logic              fflags_clr,
    output logic              err_overflow,
    output logic              err_credit
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;
    localparam int unsigned EW = DATA_W + FLAG_W;

    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [EW-1:0]     head;
    logic              deq_fire;
    logic              enq_en;
    logic              overflow;
    logic              credit_err;
    logic [SW-1:0]     credit_used;

    logic [IW-1:0]     inflight_q, inflight_d;
    logic [FLAG_W-1:0] fflags_q, fflags_d;
    logic              err_ov_q, err_ov_d;
    logic              err_cr_q, err_cr_d;

    fma_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (enq_en),
        .wr_data ({pipe_out, pipe_flags}),
        .rd_en   (deq_fire),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Handshake decode; a full FIFO still accepts when the head leaves the same cycle.
    always_comb begin
        deq_valid = ~empty;
        deq_fire  = deq_valid & deq_ready;
        enq_en    = pipe_valid & (~full | deq_fire);
        overflow  = pipe_valid & full & ~deq_fire;
        {deq_data, deq_flags} = deq_valid ? head : '0;
    end

    // Credits use registered state only; a same-cycle dequeue is not credited back.
    always_comb begin
        credit_used = SW'(count) + SW'(inflight_q);
        issue_ready = (credit_used < SW'(DEPTH)) && (inflight_q < IW'(MAX_INFLIGHT));
    end

    // In-flight counter, saturating at both ends, plus credit protocol error detection.
    always_comb begin
        inflight_d = inflight_q;
        case ({issue_fire, pipe_valid})
            2'b10: begin
                if (inflight_q != IW'(MAX_INFLIGHT)) begin
                    inflight_d = inflight_q + IW'(1);
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - IW'(1);
                end
            end
            default: inflight_d = inflight_q;
        endcase
        // Saturation on increment implies issue_ready was low, so it is covered here too.
        credit_err = (issue_fire & ~issue_ready) | (pipe_valid & (inflight_q == '0));
    end

    // Sticky flag accumulation and sticky error flags.
    always_comb begin
        fflags_d = (fflags_clr ? '0 : fflags_q) | (deq_fire ? deq_flags : '0);
        err_ov_d = err_ov_q | overflow;
        err_cr_d = err_cr_q | credit_err;
    end

    // State registers for credits, flags and errors.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight_q <= '0;
            fflags_q   <= '0;
            err_ov_q   <= 1'b0;
            err_cr_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            fflags_q   <= fflags_d;
            err_ov_q   <= err_ov_d;
            err_cr_q   <= err_cr_d;
        end
    end

    assign fflags_acc   = fflags_q;
    assign err_overflow = err_ov_q;
    assign err_credit   = err_cr_q;

endmodule

// File: tb/tb_fma_result_collector.sv
// Directed table-driven bench for fma_result_collector with hand-computed expectations.
module tb_fma_result_collector;
    import fma_collector_pkg::*;

    logic              clock;
    logic              reset;
    logic              issue_fire;
    logic              issue_ready;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_out;
    logic [FLAG_W-1:0] pipe_flags;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_data;
    logic [FLAG_W-1:0] deq_flags;
    logic [FLAG_W-1:0] fflags_acc;
    logic              fflags_clr;
    logic              err_overflow;
    logic              err_credit;

    int n_vec;
    int n_bad;

    fma_result_collector #(
        .DEPTH        (4),
        .MAX_INFLIGHT (4),
        .DATA_W       (DATA_W),
        .FLAG_W       (FLAG_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_fire   (issue_fire),
        .issue_ready  (issue_ready),
        .pipe_valid   (pipe_valid),
        .pipe_out     (pipe_out),
        .pipe_flags   (pipe_flags),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_data     (deq_data),
        .deq_flags    (deq_flags),
        .fflags_acc   (fflags_acc),
        .fflags_clr   (fflags_clr),
        .err_overflow (err_overflow),
        .err_credit   (err_credit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              issue;
        logic              pv;
        logic [DATA_W-1:0] pout;
        logic [FLAG_W-1:0] pflags;
        logic              dr;
        logic              clr;
        logic              e_dv;
        logic [DATA_W-1:0] e_data;
        logic [FLAG_W-1:0] e_flags;
        logic              e_rdy;
        logic [FLAG_W-1:0] e_acc;
        logic              e_ov;
        logic              e_cr;
    } vec_t;

    localparam logic [FLAG_W-1:0] F_NV = FLAG_W'(1 << NV);
    localparam logic [FLAG_W-1:0] F_DZ = FLAG_W'(1 << DZ);
    localparam logic [FLAG_W-1:0] F_OF = FLAG_W'(1 << OF);
    localparam logic [FLAG_W-1:0] F_NX = FLAG_W'(1 << NX);
    localparam logic [FLAG_W-1:0] F_0  = '0;
    localparam logic [DATA_W-1:0] D_A  = 65'h1_0000_0000_3FF0_0000;
    localparam logic [DATA_W-1:0] D_0  = '0;

    vec_t vecs [32];

    function automatic logic [DATA_W-1:0] val(int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk[0], 32'hDEAD_0000 ^ kk, 32'h0000_BEEF + kk};
    endfunction

    function automatic vec_t mk(logic issue, logic pv, logic [DATA_W-1:0] pout,
                                logic [FLAG_W-1:0] pflags, logic dr, logic clr, logic e_dv,
                                logic [DATA_W-1:0] e_data, logic [FLAG_W-1:0] e_flags,
                                logic e_rdy, logic [FLAG_W-1:0] e_acc, logic e_ov, logic e_cr);
        vec_t v;
        v.issue = issue; v.pv = pv; v.pout = pout; v.pflags = pflags;
        v.dr = dr; v.clr = clr; v.e_dv = e_dv; v.e_data = e_data; v.e_flags = e_flags;
        v.e_rdy = e_rdy; v.e_acc = e_acc; v.e_ov = e_ov; v.e_cr = e_cr;
        return v;
    endfunction

    task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic issue, logic pv, logic [DATA_W-1:0] pout,
                         logic [FLAG_W-1:0] pflags, logic dr, logic clr);
        issue_fire = issue;
        pipe_valid = pv;
        pipe_out   = pout;
        pipe_flags = pflags;
        deq_ready  = dr;
        fflags_clr = clr;
    endtask

    task automatic check_all(string tag, logic e_dv, logic [DATA_W-1:0] e_data,
                             logic [FLAG_W-1:0] e_flags, logic e_rdy,
                             logic [FLAG_W-1:0] e_acc, logic e_ov, logic e_cr);
        check({tag, ".deq_valid"}, deq_valid, e_dv);
        check({tag, ".deq_data"}, deq_data, e_data);
        check({tag, ".deq_flags"}, deq_flags, e_flags);
        check({tag, ".issue_ready"}, issue_ready, e_rdy);
        check({tag, ".fflags_acc"}, fflags_acc, e_acc);
        check({tag, ".err_overflow"}, err_overflow, e_ov);
        check({tag, ".err_credit"}, err_credit, e_cr);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Single op: issue, pipe latency 4, dequeue.
        vecs[0]  = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_0, 0, 0);
        vecs[1]  = mk(0, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_0, 0, 0);
        vecs[2]  = mk(0, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_0, 0, 0);
        vecs[3]  = mk(0, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_0, 0, 0);
        vecs[4]  = mk(0, 1, D_A, F_NX, 0, 0, 1, D_A, F_NX, 1, F_0, 0, 0);
        vecs[5]  = mk(0, 0, D_0, F_0, 1, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        // Credit exhaustion: four issues, four results land, FIFO full.
        vecs[6]  = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        vecs[7]  = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        vecs[8]  = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        vecs[9]  = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 0, F_NX, 0, 0);
        vecs[10] = mk(0, 1, val(1), F_0, 0, 0,  1, val(1), F_0, 0, F_NX, 0, 0);
        vecs[11] = mk(0, 1, val(2), F_NV, 0, 0, 1, val(1), F_0, 0, F_NX, 0, 0);
        vecs[12] = mk(0, 1, val(3), F_OF, 0, 0, 1, val(1), F_0, 0, F_NX, 0, 0);
        vecs[13] = mk(0, 1, val(4), F_NX, 0, 0, 1, val(1), F_0, 0, F_NX, 0, 0);
        // Dequeue with clear restores credit; then flag accumulation.
        vecs[14] = mk(0, 0, D_0, F_0, 1, 1,  1, val(2), F_NV, 1, F_0, 0, 0);
        vecs[15] = mk(0, 0, D_0, F_0, 1, 0,  1, val(3), F_OF, 1, F_NV, 0, 0);
        vecs[16] = mk(0, 0, D_0, F_0, 1, 0,  1, val(4), F_NX, 1, F_NV | F_OF, 0, 0);
        vecs[17] = mk(0, 0, D_0, F_0, 1, 1,  0, D_0, F_0, 1, F_NX, 0, 0);
        // Refill to full, then enqueue against a full FIFO.
        vecs[18] = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        vecs[19] = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        vecs[20] = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 1, F_NX, 0, 0);
        vecs[21] = mk(1, 0, D_0, F_0, 0, 0,  0, D_0, F_0, 0, F_NX, 0, 0);
        vecs[22] = mk(0, 1, val(10), F_0, 0, 0, 1, val(10), F_0, 0, F_NX, 0, 0);
        vecs[23] = mk(0, 1, val(11), F_0, 0, 0, 1, val(10), F_0, 0, F_NX, 0, 0);
        vecs[24] = mk(0, 1, val(12), F_0, 0, 0, 1, val(10), F_0, 0, F_NX, 0, 0);
        vecs[25] = mk(0, 1, val(13), F_0, 0, 0, 1, val(10), F_0, 0, F_NX, 0, 0);
        // Full + enq + deq: accepted (credit error since nothing was in flight).
        vecs[26] = mk(0, 1, val(14), F_0, 1, 0, 1, val(11), F_0, 0, F_NX, 0, 1);
        // Full + enq without deq: dropped, overflow.
        vecs[27] = mk(0, 1, val(15), F_0, 0, 0, 1, val(11), F_0, 0, F_NX, 1, 1);
        vecs[28] = mk(0, 0, D_0, F_0, 1, 0,  1, val(12), F_0, 1, F_NX, 1, 1);
        vecs[29] = mk(0, 0, D_0, F_0, 1, 0,  1, val(13), F_0, 1, F_NX, 1, 1);
        vecs[30] = mk(0, 0, D_0, F_0, 1, 0,  1, val(14), F_0, 1, F_NX, 1, 1);
        vecs[31] = mk(0, 0, D_0, F_0, 1, 0,  0, D_0, F_0, 1, F_NX, 1, 1);

        reset = 1'b0;
        drive(0, 0, D_0, F_0, 0, 0);
        #1;
        check_all("in_reset", 0, D_0, F_0, 1, F_0, 0, 0);

        @(negedge clock);
        #2 reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            drive(vecs[i].issue, vecs[i].pv, vecs[i].pout, vecs[i].pflags, vecs[i].dr,
                  vecs[i].clr);
            @(posedge clock);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_dv, vecs[i].e_data, vecs[i].e_flags,
                      vecs[i].e_rdy, vecs[i].e_acc, vecs[i].e_ov, vecs[i].e_cr);
        end

        // Buffer three entries, then assert reset between clock edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(0, 1, val(20 + k), F_DZ, 0, 0);
            @(posedge clock);
            #1;
        end
        check_all("pre_async", 1, val(20), F_DZ, 1, F_NX, 1, 1);
        drive(0, 0, D_0, F_0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, D_0, F_0, 1, F_0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all("post_reset", 0, D_0, F_0, 1, F_0, 0, 0);

        // Result with nothing in flight is a credit error but is still captured.
        @(negedge clock);
        drive(0, 1, val(30), F_NX, 0, 0);
        @(posedge clock);
        #1;
        check_all("no_inflight", 1, val(30), F_NX, 1, F_0, 0, 1);
        @(negedge clock);
        drive(0, 0, D_0, F_0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
